// File: rtl/pe_array_ctrl.sv
// Sequencer for a chain of N PE_H elements: clears partial sums, feeds K+N-1
// skewed beats, then loads and shifts the N results out of the chain end.
module pe_array_ctrl #(
  parameter int unsigned N  = 16,
  parameter int unsigned KW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] cfg_len,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          in_ready,
  output logic          en_in,
  output logic          en_psum,
  output logic          clear_psum,
  output logic          en_out,
  output logic          output_eject_ctrl,
  output logic          out_valid,
  output logic          out_last
);

  localparam int unsigned BW = KW + 1;
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    LOAD  = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [BW-1:0] beat_cnt;
  logic [OW-1:0] out_cnt;
  logic          load_q;
  logic [BW-1:0] beat_target;

  // Skew means the last PE needs K+N-1 beats before its sum is complete.
  assign beat_target = BW'(k_q) + BW'(N - 1);

  // Feed and shift handshakes must react within the cycle.
  assign en_in    = (state == FEED) && in_valid;
  assign in_ready = en_in;
  assign en_out   = load_q || (out_valid && out_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      k_q               <= '0;
      beat_cnt          <= '0;
      out_cnt           <= '0;
      load_q            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      en_psum           <= 1'b0;
      clear_psum        <= 1'b0;
      output_eject_ctrl <= 1'b0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
    end else begin
      en_psum    <= en_in;
      done       <= 1'b0;
      clear_psum <= 1'b0;
      load_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            k_q        <= cfg_len;
            beat_cnt   <= '0;
            out_cnt    <= '0;
            busy       <= 1'b1;
            clear_psum <= 1'b1;
          end
        end
        CLEAR: begin
          if (k_q != '0) begin
            state <= FEED;
          end else begin
            state  <= LOAD;
            load_q <= 1'b1;
          end
        end
        FEED: begin
          if (in_valid) begin
            beat_cnt <= beat_cnt + BW'(1);
            if ((beat_cnt + BW'(1)) == beat_target) state <= FLUSH;
          end
        end
        FLUSH: begin
          state  <= LOAD;
          load_q <= 1'b1;
        end
        LOAD: begin
          state             <= SHIFT;
          out_valid         <= 1'b1;
          output_eject_ctrl <= 1'b1;
          out_last          <= 1'b0;
        end
        SHIFT: begin
          if (out_ready) begin
            out_cnt <= out_cnt + OW'(1);
            if (out_last) begin
              state             <= DONE;
              out_valid         <= 1'b0;
              output_eject_ctrl <= 1'b0;
              out_last          <= 1'b0;
              done              <= 1'b1;
            end else begin
              out_last <= (out_cnt + OW'(1)) == OW'(N - 1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
